dmem_noc_router_1ton: RTL

Parametrised 1-master to N-slave data-memory NoC router on the `mem_req_t`/`mem_resp_t` handshake. It decodes each request address against a per-slave base/mask table and forwards the request to the matching slave. It keeps up to `MAX_OUTST` requests outstanding to a single slave and steers multi-beat responses back to the master in order. It sits between the LSU-side dmem master and the debug/ITCM/DTCM/peripheral slaves, and replaces the fixed 1-to-4 single-outstanding router.

---
 rtl/dmem_noc_router_1ton.sv | 139 +++++++++++++
 1 files changed

// File: rtl/dmem_noc_router_1ton.sv
// rtl/dmem_noc_router_1ton.sv - 1-master to N-slave dmem router with in-order outstanding tracking
//
// Purpose: decodes each master request against a per-slave base/mask table,
// forwards it to one slave, and steers that slave's (possibly multi-beat)
// responses back to the master. Up to MAX_OUTST requests may be in flight,
// all to the same slave, so responses come back in order without reordering.
//
// Ports:
//   clk, rst                                    clock, sync active-high reset
//   mn_req_valid/mn_req_ready/mn_req            master request handshake
//   mn_resp_valid/mn_resp_ready/mn_resp         master response handshake
//   sn_req_valid/sn_req_ready/sn_req   [N_SLV]  slave request handshakes
//   sn_resp_valid/sn_resp_ready/sn_resp[N_SLV]  slave response handshakes
//   outst_cnt                                   outstanding request count
//   route_stall                                 request held by order/full rule

package dmem_noc_router_pkg;
  typedef struct packed {
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        req_we;
  } mem_req_t;

  typedef struct packed {
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        resp_last;
  } mem_resp_t;
endpackage

module dmem_noc_router_1ton
  import dmem_noc_router_pkg::*;
#(
  parameter int                       N_SLV       = 4,
  parameter int                       MAX_OUTST   = 4,
  // index 0 sits in the least significant word
  parameter logic [N_SLV-1:0][31:0]   SLV_BASE    = {32'h0, 32'h8008_0000, 32'h8000_0000, 32'h0000_0000},
  parameter logic [N_SLV-1:0][31:0]   SLV_MASK    = {32'h0, 32'hFFF8_0000, 32'hFFF8_0000, 32'hF000_0000},
  parameter int                       DEFAULT_SLV = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              mn_req_valid,
  output logic                              mn_req_ready,
  input  mem_req_t                          mn_req,
  output logic                              mn_resp_valid,
  input  logic                              mn_resp_ready,
  output mem_resp_t                         mn_resp,
  output logic [N_SLV-1:0]                  sn_req_valid,
  input  logic [N_SLV-1:0]                  sn_req_ready,
  output mem_req_t [N_SLV-1:0]              sn_req,
  input  logic [N_SLV-1:0]                  sn_resp_valid,
  output logic [N_SLV-1:0]                  sn_resp_ready,
  input  mem_resp_t [N_SLV-1:0]             sn_resp,
  output logic [$clog2(MAX_OUTST+1)-1:0]    outst_cnt,
  output logic                              route_stall
);

  localparam int CW = $clog2(MAX_OUTST + 1);
  localparam int TW = $clog2(N_SLV);

  logic [CW-1:0] r_cnt;
  logic [TW-1:0] r_cur_tid;

  logic [TW-1:0] w_tgt;
  logic          w_run;
  logic          w_busy;
  logic          w_acc_ok;
  logic          w_push;
  logic          w_pop;

  // Address decode: scan from the top down so the lowest matching index wins.
  always_comb begin
    w_tgt = TW'(DEFAULT_SLV);
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if ((SLV_MASK[i] != 32'h0) &&
          ((mn_req.req_addr & SLV_MASK[i]) == (SLV_BASE[i] & SLV_MASK[i]))) begin
        w_tgt = TW'(i);
      end
    end
  end

  assign w_run  = !rst;
  assign w_busy = (r_cnt != '0);

  // Only registered state feeds acceptance: a response popping this cycle
  // never frees a slot combinationally, which keeps resp->req paths cut.
  assign w_acc_ok = ((r_cnt == '0) || (w_tgt == r_cur_tid)) && (r_cnt < CW'(MAX_OUTST));

  always_comb begin
    sn_req_valid  = '0;
    sn_resp_ready = '0;
    for (int i = 0; i < N_SLV; i++) begin
      sn_req[i] = mn_req;
    end
    if (w_run && mn_req_valid && w_acc_ok) begin
      sn_req_valid[w_tgt] = 1'b1;
    end
    if (w_run && w_busy && mn_resp_ready) begin
      sn_resp_ready[r_cur_tid] = 1'b1;
    end
  end

  assign mn_req_ready  = w_run && w_acc_ok && sn_req_ready[w_tgt];
  assign route_stall   = w_run && mn_req_valid && !w_acc_ok;
  assign mn_resp_valid = w_run && w_busy && sn_resp_valid[r_cur_tid];
  assign mn_resp       = sn_resp[r_cur_tid];
  assign outst_cnt     = w_run ? r_cnt : '0;

  assign w_push = mn_req_valid && mn_req_ready;
  assign w_pop  = mn_resp_valid && mn_resp_ready && mn_resp.resp_last;

  // Only the last beat of a response retires an outstanding request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_cur_tid <= TW'(DEFAULT_SLV);
    end else begin
      if (w_push) begin
        r_cur_tid <= w_tgt;
      end
      if (w_push && !w_pop) begin
        r_cnt <= r_cnt + CW'(1);
      end else if (w_pop && !w_push) begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

`ifndef SYNTHESIS
  a_cnt_max: assert property (@(posedge clk) disable iff (rst) r_cnt <= CW'(MAX_OUTST));
  a_cnt_min: assert property (@(posedge clk) disable iff (rst) !(w_pop && !w_push && (r_cnt == '0)));
`ifdef DMEM_NOC_DEBUG
  a_spurious_resp: assert property (@(posedge clk) disable iff (rst) !((r_cnt == '0) && (|sn_resp_valid)));
`endif
`endif

endmodule
